// File: rtl/cache_ctrl_if.sv
// Request/response and memory-side bundle for cache_ctrl.
// master: the client plus the memory block. slave: the controller.
interface cache_if #(
  parameter int unsigned KEY_WIDTH   = 16,
  parameter int unsigned VALUE_WIDTH = 64
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [KEY_WIDTH-1:0]   req_key;
  logic [VALUE_WIDTH-1:0] req_value;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [1:0]             resp_status;
  logic [VALUE_WIDTH-1:0] resp_value;
  logic [1:0]             mem_op;
  logic [KEY_WIDTH-1:0]   mem_key;
  logic [VALUE_WIDTH-1:0] mem_value;
  logic                   mem_hit;
  logic [VALUE_WIDTH-1:0] mem_rdata;
  logic                   mem_full;

  modport master (
    output req_valid, req_op, req_key, req_value, resp_ready,
           mem_hit, mem_rdata, mem_full,
    input  req_ready, resp_valid, resp_status, resp_value,
           mem_op, mem_key, mem_value
  );

  modport slave (
    input  req_valid, req_op, req_key, req_value, resp_ready,
           mem_hit, mem_rdata, mem_full,
    output req_ready, resp_valid, resp_status, resp_value,
           mem_op, mem_key, mem_value
  );
endinterface

// File: rtl/cache_ctrl.sv
// Key/value cache controller: one outstanding GET/SET/DEL at a time,
// sequencing a lookup and optional write against an external memory block.
module cache_ctrl #(
  parameter int unsigned KEY_WIDTH   = 16,
  parameter int unsigned VALUE_WIDTH = 64
) (
  input logic   clk,
  input logic   rst_n,
  cache_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, RESP} state_t;
  typedef enum logic [1:0] {OP_GET = 2'b00, OP_SET = 2'b01, OP_DEL = 2'b10, OP_BAD = 2'b11} op_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_BADOP = 2'b11} status_t;
  typedef enum logic [1:0] {MEM_NOP = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b10, MEM_DELETE = 2'b11} mem_op_t;

  state_t                 state;
  op_t                    op_q;
  logic [KEY_WIDTH-1:0]   key_in;
  logic [VALUE_WIDTH-1:0] value_in;
  logic [VALUE_WIDTH-1:0] hit_data;

  always_comb begin
    key_in   = bus.req_key;
    value_in = bus.req_value;
    hit_data = bus.mem_hit ? bus.mem_rdata : '0;
  end

  // Lookup results are consumed on the edge closing LOOKUP, so the decision
  // and the registered response are both taken from that single sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= OP_GET;
      bus.req_ready   <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_status <= ST_OK;
      bus.resp_value  <= '0;
      bus.mem_op      <= MEM_NOP;
      bus.mem_key     <= '0;
      bus.mem_value   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            op_q          <= op_t'(bus.req_op);
            bus.mem_key   <= key_in;
            bus.mem_value <= value_in;
            bus.req_ready <= 1'b0;
            if (op_t'(bus.req_op) == OP_BAD) begin
              state           <= RESP;
              bus.resp_valid  <= 1'b1;
              bus.resp_status <= ST_BADOP;
            end else begin
              state      <= LOOKUP;
              bus.mem_op <= MEM_READ;
            end
          end
        end
        LOOKUP: begin
          bus.mem_op <= MEM_NOP;
          case (op_q)
            OP_SET: begin
              if (bus.mem_hit || !bus.mem_full) begin
                state      <= WRITE;
                bus.mem_op <= MEM_WRITE;
              end else begin
                state           <= RESP;
                bus.resp_valid  <= 1'b1;
                bus.resp_status <= ST_FULL;
              end
            end
            OP_DEL: begin
              if (bus.mem_hit) begin
                state      <= WRITE;
                bus.mem_op <= MEM_DELETE;
              end else begin
                state           <= RESP;
                bus.resp_valid  <= 1'b1;
                bus.resp_status <= ST_MISS;
              end
            end
            default: begin
              state           <= RESP;
              bus.resp_valid  <= 1'b1;
              bus.resp_status <= bus.mem_hit ? ST_OK : ST_MISS;
              bus.resp_value  <= hit_data;
            end
          endcase
        end
        WRITE: begin
          bus.mem_op      <= MEM_NOP;
          state           <= RESP;
          bus.resp_valid  <= 1'b1;
          bus.resp_status <= ST_OK;
          bus.resp_value  <= '0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_status <= ST_OK;
            bus.resp_value  <= '0;
            bus.req_ready   <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a 4-entry memory block, a dictionary-level
// reference model producing per-cycle expected frames, and literal pins.
module tb_cache_ctrl;

  logic clk;
  logic rst_n;

  cache_if #(.KEY_WIDTH(16), .VALUE_WIDTH(64)) bus ();

  cache_ctrl #(.KEY_WIDTH(16), .VALUE_WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory block: 4 slots, combinational match, writes on the clock edge.
  logic        m_valid [4];
  logic [15:0] m_key   [4];
  logic [63:0] m_val   [4];
  logic        force_full;

  always_comb begin
    bus.mem_hit   = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_full  = force_full;
    if (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3]) bus.mem_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_key[i] == bus.mem_key) begin
        bus.mem_hit   = 1'b1;
        bus.mem_rdata = m_val[i];
      end
    end
  end

  always @(posedge clk) begin
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_key[i] == bus.mem_key) idx = i;
    if (bus.mem_op == 2'b10) begin
      if (idx < 0)
        for (int i = 3; i >= 0; i--)
          if (!m_valid[i]) idx = i;
      if (idx >= 0) begin
        m_valid[idx] <= 1'b1;
        m_key[idx]   <= bus.mem_key;
        m_val[idx]   <= bus.mem_value;
      end
    end else if (bus.mem_op == 2'b11 && idx >= 0) begin
      m_valid[idx] <= 1'b0;
    end
  end

  // Reference model: dictionary contents plus expected per-cycle outputs.
  typedef struct {
    logic        rr;
    logic        rv;
    logic [1:0]  st;
    logic [63:0] val;
    logic [1:0]  mop;
    logic [15:0] mk;
    logic [63:0] mv;
  } frame_t;

  logic [63:0] ref_kv [logic [15:0]];
  frame_t      exp_q [$];
  logic [15:0] last_key;
  logic [63:0] last_val;
  logic        ready_lag;

  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      f = '{1'b0, 1'b0, 2'b00, 64'h0, 2'b00, 16'h0, 64'h0};
    end else if (exp_q.size() > 0) begin
      f = exp_q.pop_front();
    end else begin
      f = '{!ready_lag, 1'b0, 2'b00, 64'h0, 2'b00, last_key, last_val};
      ready_lag = 1'b0;
    end
    check("req_ready",   {63'h0, bus.req_ready},   {63'h0, f.rr});
    check("resp_valid",  {63'h0, bus.resp_valid},  {63'h0, f.rv});
    check("resp_status", {62'h0, bus.resp_status}, {62'h0, f.st});
    check("resp_value",  bus.resp_value,           f.val);
    check("mem_op",      {62'h0, bus.mem_op},      {62'h0, f.mop});
    check("mem_key",     {48'h0, bus.mem_key},     {48'h0, f.mk});
    check("mem_value",   bus.mem_value,            f.mv);
  end

  task automatic do_txn(input logic [1:0] op, input logic [15:0] key, input logic [63:0] val,
                        input int hold, input bit early, input int lit_lat,
                        input logic [1:0] lit_st, input logic [63:0] lit_val);
    bit hit, full, wr;
    int lat;
    logic [1:0] st, wop;
    logic [63:0] rv;
    hit  = ref_kv.exists(key);
    full = force_full || (ref_kv.num() >= 4);
    wr = 1'b0; wop = 2'b00; rv = 64'h0;
    case (op)
      2'b00: begin lat = 2; st = hit ? 2'b00 : 2'b01; if (hit) rv = ref_kv[key]; end
      2'b01: begin
        wr = hit || !full; wop = 2'b10;
        lat = wr ? 3 : 2; st = wr ? 2'b00 : 2'b10;
        if (wr) ref_kv[key] = val;
      end
      2'b10: begin
        wr = hit; wop = 2'b11;
        lat = wr ? 3 : 2; st = wr ? 2'b00 : 2'b01;
        if (wr) ref_kv.delete(key);
      end
      default: begin lat = 1; st = 2'b11; end
    endcase
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_value = val;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    last_key = key;
    last_val = val;
    for (int k = 1; k <= lat + hold; k++) begin
      if (k < lat)
        exp_q.push_back('{1'b0, 1'b0, 2'b00, 64'h0,
                          (k == 1) ? 2'b01 : wop, key, val});
      else
        exp_q.push_back('{1'b0, 1'b1, st, rv, 2'b00, key, val});
    end
    for (int k = 1; k <= lat + hold; k++) begin
      bus.resp_ready = (k < lat) ? early : (k == lat + hold);
      if (k == lit_lat) begin
        check("lit_resp_valid",  {63'h0, bus.resp_valid},  64'h1);
        check("lit_resp_status", {62'h0, bus.resp_status}, {62'h0, lit_st});
        check("lit_resp_value",  bus.resp_value,           lit_val);
      end
      @(posedge clk); #2;
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    last_key = '0;
    last_val = '0;
    repeat (cycles) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ready_lag = 1'b1;
    @(posedge clk); #2;
  endtask

  // SET interrupted by reset while the WRITE is on the memory port.
  task automatic set_with_reset(input logic [15:0] key, input logic [63:0] val);
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_key   = key;
    bus.req_value = val;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    last_key = key;
    last_val = val;
    exp_q.push_back('{1'b0, 1'b0, 2'b00, 64'h0, 2'b01, key, val});
    @(posedge clk); #2;
    check("rst_pre_write", {62'h0, bus.mem_op}, 64'h2);
    rst_n = 1'b0;
    #1;
    check("rst_async_nop",   {62'h0, bus.mem_op},  64'h0);
    check("rst_async_rvld",  {63'h0, bus.resp_valid}, 64'h0);
    #1;
    do_reset(2);
  endtask

  initial begin
    rst_n = 1'b0;
    force_full = 1'b0;
    ready_lag = 1'b0;
    last_key = '0;
    last_val = '0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_key[i]   = '0;
      m_val[i]   = '0;
    end
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_key    = '0;
    bus.req_value  = '0;
    bus.resp_ready = 1'b0;
    #1;
    do_reset(3);

    do_txn(2'b01, 16'h00A1, 64'h1122334455667788, 0, 1'b1, 3, 2'b00, 64'h0);
    do_txn(2'b00, 16'h00A1, 64'h0, 0, 1'b0, 2, 2'b00, 64'h1122334455667788);
    do_txn(2'b00, 16'h00B2, 64'h5A5A, 0, 1'b1, 2, 2'b01, 64'h0);
    do_txn(2'b11, 16'h0055, 64'h77, 0, 1'b0, 1, 2'b11, 64'h0);
    force_full = 1'b1;
    do_txn(2'b01, 16'h00C3, 64'hCAFE, 0, 1'b0, 2, 2'b10, 64'h0);
    force_full = 1'b0;
    do_txn(2'b10, 16'h00D4, 64'h0, 0, 1'b0, 2, 2'b01, 64'h0);
    do_txn(2'b01, 16'h00A1, 64'hDEADBEEF00000001, 5, 1'b0, 3, 2'b00, 64'h0);
    do_txn(2'b00, 16'h00A1, 64'h0, 5, 1'b0, 7, 2'b00, 64'hDEADBEEF00000001);
    do_txn(2'b01, 16'h00B2, 64'hB2B2, 0, 1'b0, 0, 2'b00, 64'h0);
    do_txn(2'b01, 16'h00C3, 64'hC3C3, 0, 1'b0, 0, 2'b00, 64'h0);
    do_txn(2'b01, 16'h00D4, 64'hD4D4, 0, 1'b0, 0, 2'b00, 64'h0);
    do_txn(2'b01, 16'h00E5, 64'hE5E5, 0, 1'b0, 2, 2'b10, 64'h0);
    do_txn(2'b00, 16'h00C3, 64'h0, 1, 1'b0, 2, 2'b00, 64'hC3C3);
    do_txn(2'b10, 16'h00B2, 64'h0, 0, 1'b0, 3, 2'b00, 64'h0);
    do_txn(2'b00, 16'h00B2, 64'h0, 0, 1'b0, 2, 2'b01, 64'h0);
    do_txn(2'b01, 16'h00E5, 64'hE5E5, 0, 1'b1, 3, 2'b00, 64'h0);
    do_txn(2'b10, 16'h00C3, 64'h0, 0, 1'b0, 0, 2'b00, 64'h0);
    set_with_reset(16'h0077, 64'h7777777777777777);
    do_txn(2'b00, 16'h0077, 64'h0, 0, 1'b0, 2, 2'b01, 64'h0);
    do_txn(2'b00, 16'h00E5, 64'h0, 0, 1'b0, 2, 2'b00, 64'hE5E5);
    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
